// File: rtl/clk_updn_pkg.sv
// rtl/clk_updn_pkg.sv - shared legal-range constants and parameter check for the up/down mod-N counter
package clk_updn_pkg;

    localparam int MOD_MIN  = 2;
    localparam int MOD_MAX  = 16;
    localparam int NDIG_MIN = 1;
    localparam int NDIG_MAX = 8;

    function automatic bit params_ok(input int mod, input int ndig);
        return (mod >= MOD_MIN) && (mod <= MOD_MAX) &&
               (ndig >= NDIG_MIN) && (ndig <= NDIG_MAX);
    endfunction

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - one-bit full adder cell
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/updn_digit.sv
// rtl/updn_digit.sv - one mod-MOD digit: register, +/-1 ripple adder, boundary override, clamped load
module updn_digit #(
    parameter int MOD = 10,
    parameter int DW  = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_en,
    input  logic          up,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] q,
    output logic          at_max,
    output logic          at_min,
    output logic          ld_err
);

    localparam logic [DW-1:0] MAX_V = DW'(MOD - 1);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [DW-1:0] sum;
    logic [DW:0]   carry;
    logic          unused_carry_out;

    // q + {DW{~up}} + up: adding all-ones with carry-in 0 is -1, adding zero with carry-in 1 is +1
    assign carry[0] = up;

    for (genvar i = 0; i < DW; i++) begin : g_add
        fa u_fa (
            .a  (q_q[i]),
            .b  (~up),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign unused_carry_out = carry[DW];

    assign at_max = (q_q == MAX_V);
    assign at_min = (q_q == '0);
    assign ld_err = load & ({1'b0, load_val} >= (DW + 1)'(MOD));
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = ld_err ? MAX_V : load_val;
        end else if (step_en) begin
            if (up && at_max) begin
                q_d = '0;
            end else if (!up && at_min) begin
                q_d = MAX_V;
            end else begin
                q_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/clk_updnmodn.sv
// rtl/clk_updnmodn.sv - NDIG cascaded mod-MOD up/down counter with load, terminal count and wrap pulse
module clk_updnmodn
    import clk_updn_pkg::*;
#(
    parameter int MOD  = 10,
    parameter int NDIG = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [NDIG*$clog2(MOD)-1:0] load_val,
    output logic [NDIG*$clog2(MOD)-1:0] cnt,
    output logic                      tc,
    output logic                      wrap,
    output logic                      load_err
);

    localparam int DW = $clog2(MOD);

    if (!params_ok(MOD, NDIG)) begin : g_param_err
        $fatal(1, "clk_updnmodn: MOD must be 2..16 and NDIG 1..8");
    end

    logic [NDIG-1:0] at_max;
    logic [NDIG-1:0] at_min;
    logic [NDIG-1:0] ld_err;
    logic [NDIG-1:0] step_en;
    logic [NDIG:0]   all_max;
    logic [NDIG:0]   all_min;

    logic wrap_q;
    logic wrap_d;
    logic load_err_q;
    logic load_err_d;

    // all_max[k] / all_min[k]: every digit below k sits at its boundary
    assign all_max[0] = 1'b1;
    assign all_min[0] = 1'b1;

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        assign all_max[k+1] = all_max[k] & at_max[k];
        assign all_min[k+1] = all_min[k] & at_min[k];
        assign step_en[k]   = en & (up ? all_max[k] : all_min[k]);

        updn_digit #(
            .MOD (MOD),
            .DW  (DW)
        ) u_digit (
            .clk      (clk),
            .reset    (reset),
            .step_en  (step_en[k]),
            .up       (up),
            .load     (load),
            .load_val (load_val[k*DW +: DW]),
            .q        (cnt[k*DW +: DW]),
            .at_max   (at_max[k]),
            .at_min   (at_min[k]),
            .ld_err   (ld_err[k])
        );
    end

    assign tc         = en & ~load & (up ? all_max[NDIG] : all_min[NDIG]);
    assign wrap_d     = tc;
    assign load_err_d = |ld_err;
    assign wrap       = wrap_q;
    assign load_err   = load_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

endmodule

// File: tb/tb_clk_updnmodn.sv
// tb/tb_clk_updnmodn.sv - directed table-driven bench for clk_updnmodn at three parameter sets
module tb_clk_updnmodn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // default instance: MOD=10, NDIG=2
    logic       rst_a, en_a, up_a, ld_a;
    logic [7:0] lv_a, cnt_a;
    logic       tc_a, wrap_a, lerr_a;

    // second instance: single hex digit
    logic       rst_b, en_b, up_b, ld_b;
    logic [3:0] lv_b, cnt_b;
    logic       tc_b, wrap_b, lerr_b;

    // third instance: three mod-6 digits
    logic       rst_c, en_c, up_c, ld_c;
    logic [8:0] lv_c, cnt_c;
    logic       tc_c, wrap_c, lerr_c;

    clk_updnmodn u_dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .up(up_a), .load(ld_a), .load_val(lv_a),
        .cnt(cnt_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a)
    );

    clk_updnmodn #(.MOD(16), .NDIG(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .up(up_b), .load(ld_b), .load_val(lv_b),
        .cnt(cnt_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b)
    );

    clk_updnmodn #(.MOD(6), .NDIG(3)) u_dut_c (
        .clk(clk), .reset(rst_c), .en(en_c), .up(up_c), .load(ld_c), .load_val(lv_c),
        .cnt(cnt_c), .tc(tc_c), .wrap(wrap_c), .load_err(lerr_c)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       ld;
        logic [7:0] lv;
        logic       tc;   // expected before the edge
        logic [7:0] cnt;  // expected after the edge
        logic       w;
        logic       e;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int val;
        int nwrap;
        logic exp_w;

        rst_a = 1; en_a = 0; up_a = 1; ld_a = 0; lv_a = '0;
        rst_b = 1; en_b = 0; up_b = 1; ld_b = 0; lv_b = '0;
        rst_c = 1; en_c = 0; up_c = 1; ld_c = 0; lv_c = '0;
        tick();
        chk("rst_cnt_a", cnt_a, 8'h00);
        chk("rst_wrap_a", wrap_a, 1'b0);
        chk("rst_lerr_a", lerr_a, 1'b0);
        chk("rst_cnt_b", cnt_b, 4'h0);
        chk("rst_cnt_c", cnt_c, 9'h000);

        //             rst en up ld lv     tc cnt    w  e
        vt.push_back('{1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0});
        vt.push_back('{0, 0, 1, 1, 8'h47, 0, 8'h47, 0, 0});
        vt.push_back('{0, 1, 1, 1, 8'h4C, 0, 8'h49, 0, 1});
        vt.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h49, 0, 0});
        vt.push_back('{0, 0, 1, 1, 8'h09, 0, 8'h09, 0, 0});
        vt.push_back('{0, 1, 1, 0, 8'h00, 0, 8'h10, 0, 0});
        vt.push_back('{0, 1, 0, 0, 8'h00, 0, 8'h09, 0, 0});
        for (int i = 0; i < 5; i++)
            vt.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h09, 0, 0});
        vt.push_back('{0, 0, 1, 1, 8'h99, 0, 8'h99, 0, 0});
        vt.push_back('{0, 1, 1, 0, 8'h00, 1, 8'h00, 1, 0});
        vt.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h99, 1, 0});
        vt.push_back('{0, 1, 1, 0, 8'h00, 1, 8'h00, 1, 0});
        vt.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0});
        vt.push_back('{0, 0, 1, 1, 8'h57, 0, 8'h57, 0, 0});
        vt.push_back('{1, 1, 1, 1, 8'hCC, 0, 8'h00, 0, 0});
        vt.push_back('{0, 0, 1, 1, 8'hCC, 0, 8'h99, 0, 1});
        vt.push_back('{1, 1, 1, 0, 8'h00, 1, 8'h00, 0, 0});
        vt.push_back('{0, 0, 1, 1, 8'hA3, 0, 8'h93, 0, 1});
        vt.push_back('{1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0});
        vt.push_back('{0, 1, 0, 0, 8'h00, 1, 8'h99, 1, 0});
        vt.push_back('{0, 1, 0, 0, 8'h00, 0, 8'h98, 0, 0});
        vt.push_back('{0, 1, 1, 1, 8'h59, 0, 8'h59, 0, 0});
        vt.push_back('{0, 1, 1, 0, 8'h00, 0, 8'h60, 0, 0});

        foreach (vt[i]) begin
            rst_a = vt[i].rst; en_a = vt[i].en; up_a = vt[i].up;
            ld_a = vt[i].ld; lv_a = vt[i].lv;
            #1;
            chk($sformatf("vec%0d_tc", i), tc_a, vt[i].tc);
            tick();
            chk($sformatf("vec%0d_cnt", i), cnt_a, vt[i].cnt);
            chk($sformatf("vec%0d_wrap", i), wrap_a, vt[i].w);
            chk($sformatf("vec%0d_lerr", i), lerr_a, vt[i].e);
        end

        // full up count 00..99..00
        rst_a = 1; en_a = 0; ld_a = 0; up_a = 1;
        tick();
        rst_a = 0; en_a = 1;
        val = 0;
        nwrap = 0;
        for (int i = 0; i < 101; i++) begin
            #1;
            chk($sformatf("up%0d_tc", i), tc_a, (val == 99));
            exp_w = (val == 99);
            val = (val + 1) % 100;
            tick();
            chk($sformatf("up%0d_cnt", i), cnt_a, bcd(val));
            chk($sformatf("up%0d_wrap", i), wrap_a, exp_w);
            if (wrap_a === 1'b1) nwrap++;
        end
        chk("up_wrap_count", nwrap, 1);
        en_a = 0;

        // single hex digit: natural wrap both directions
        rst_b = 0; ld_b = 1; lv_b = 4'hF;
        tick();
        chk("b_load_cnt", cnt_b, 4'hF);
        ld_b = 0; en_b = 1; up_b = 1;
        #1;
        chk("b_tc_up", tc_b, 1'b1);
        tick();
        chk("b_wrap_cnt", cnt_b, 4'h0);
        chk("b_wrap", wrap_b, 1'b1);
        up_b = 0;
        #1;
        chk("b_tc_dn", tc_b, 1'b1);
        tick();
        chk("b_dn_cnt", cnt_b, 4'hF);
        chk("b_lerr", lerr_b, 1'b0);
        en_b = 0;

        // three mod-6 digits: wrap, carry and load clamp
        rst_c = 0; ld_c = 1; lv_c = {3'd5, 3'd5, 3'd5};
        tick();
        chk("c_load_cnt", cnt_c, {3'd5, 3'd5, 3'd5});
        ld_c = 0; en_c = 1; up_c = 1;
        #1;
        chk("c_tc", tc_c, 1'b1);
        tick();
        chk("c_wrap_cnt", cnt_c, 9'h000);
        chk("c_wrap", wrap_c, 1'b1);
        up_c = 0;
        tick();
        chk("c_dn_cnt", cnt_c, {3'd5, 3'd5, 3'd5});
        en_c = 0; ld_c = 1; lv_c = {3'd0, 3'd5, 3'd5};
        tick();
        en_c = 1; up_c = 1; ld_c = 0;
        tick();
        chk("c_carry_cnt", cnt_c, {3'd1, 3'd0, 3'd0});
        chk("c_carry_wrap", wrap_c, 1'b0);
        en_c = 0; ld_c = 1; lv_c = {3'd7, 3'd2, 3'd1};
        tick();
        chk("c_clamp_cnt", cnt_c, {3'd5, 3'd2, 3'd1});
        chk("c_clamp_lerr", lerr_c, 1'b1);
        ld_c = 0;
        tick();
        chk("c_lerr_clear", lerr_c, 1'b0);
        chk("c_hold_cnt", cnt_c, {3'd5, 3'd2, 3'd1});

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/clk_updnmodn.md
CLK_UPDNMODN -- requirements
Module: clk_updnmodn

Interface
REQ-001 Parameter MOD, default 10: modulus of every digit; legal range 2..16.
REQ-002 Parameter NDIG, default 2: number of cascaded digits; legal range 1..8.
REQ-003 Derived localparam DW = $clog2(MOD): bits per digit; total count width is NDIG*DW.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable.
REQ-007 up  input  1  direction: 1 = up, 0 = down; may change on any cycle.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  NDIG*DW  load value; digit k is bits [k*DW +: DW], digit 0 is least significant.
REQ-010 cnt  output  NDIG*DW  registered count, same digit packing as load_val.
REQ-011 tc  output  1  combinational terminal count.
REQ-012 wrap  output  1  registered one-cycle pulse on a full-chain wrap.
REQ-013 load_err  output  1  registered one-cycle pulse on an illegal load digit.

Function
REQ-014 Priority per rising edge: reset > load > en; with none active, all state holds.
REQ-015 load=1: each digit takes its load_val digit next cycle; no count step occurs, regardless of en.
REQ-016 Illegal load digit (value >= MOD): that digit takes MOD-1; load_err=1 next cycle; legal digits load unchanged.
REQ-017 en=1, up=1, digit 0: increments every cycle; at MOD-1 it goes to 0.
REQ-018 en=1, up=1, digit k>0: steps only when all lower digits equal MOD-1; at MOD-1 it goes to 0.
REQ-019 en=1, up=0, digit 0: decrements every cycle; at 0 it goes to MOD-1.
REQ-020 en=1, up=0, digit k>0: steps only when all lower digits equal 0; at 0 it goes to MOD-1.
REQ-021 Digit step arithmetic: DW-bit sum a + {DW{~up}} + up, i.e. ±1 in two's complement, truncated to DW bits. Boundary values are overridden by REQ-017..020 before truncation matters.
REQ-022 tc = en & ~load & (up ? all digits == MOD-1 : all digits == 0). Zero latency; no dependence on reset.
REQ-023 wrap = 1 in the cycle after any clock edge where tc=1 and reset=0; otherwise 0.
REQ-024 Direction reversal needs no idle cycle: each edge uses the up value sampled at that edge.
REQ-025 When MOD = 2**DW, digits wrap naturally; the result is identical to REQ-017..020.

Reset
REQ-026 reset=1 at an edge: cnt = 0, wrap = 0 and load_err = 0 next cycle, overriding load and en.
REQ-027 No state other than cnt, wrap and load_err; reset mid-count or mid-load leaves no residual effect.

Structure
REQ-028 Shared package clk_updn_pkg holds the MOD/NDIG legal-range constants and a parameter-check function; elaboration fails on out-of-range MOD or NDIG.
REQ-029 Sub-module updn_digit (parameters MOD, DW) holds one digit register plus its step logic and boundary override.
- Inputs: step_en, up, load, load_val.
- Outputs: q, at_max, at_min, ld_err.
REQ-030 updn_digit builds its ±1 adder as a DW-bit ripple of the existing fa cell.
REQ-031 Top level: generate loop of NDIG updn_digit instances. Enable chain for digit k:
- up: en & AND(at_max of digits 0..k-1)
- down: en & AND(at_min of digits 0..k-1)

Verification (MOD=10, NDIG=2 unless stated)
REQ-032 Up count: reset 1 cycle, then en=1, up=1 for 101 cycles -> cnt runs 00..99 then 00; tc=1 only at 99; wrap=1 exactly one cycle, at cnt=00.
REQ-033 Down wrap: after reset, en=1, up=0 -> tc=1 at 00; cnt=99 after 1 edge, 98 after 2; wrap pulses once.
REQ-034 Load: load_val=0x47 -> cnt=47, load_err=0. Then load_val=0x4C -> cnt=49, load_err=1 one cycle. load=1 with en=1 -> no count step.
REQ-035 Digit boundary: cnt=09, up=1 -> 10; then up=0 -> 09; then en=0 for 5 cycles -> holds 09, tc=0.
REQ-036 Reset override: reset=1 with load=1, en=1, cnt=57 -> cnt=00, wrap=0, load_err=0 next cycle.
REQ-037 Parameter sweep: MOD=16, NDIG=1 -> F wraps to 0, DW=4. MOD=6, NDIG=3, DW=3 -> 555 up wraps to 000, wrap pulse; load digit 7 -> 5 with load_err.
